// File: rtl/fc_argmax_collector.sv
// Captures one frame of signed logits, tracks the running argmax and
// presents it on a valid/ready port, with registered per-logit readback.
module fc_argmax_collector #(
    parameter int N_OUT  = 10,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_en_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [IDX_W-1:0]  res_idx_o,
    output logic [DATA_W-1:0] res_max_o,
    output logic              busy_o,
    output logic              err_o,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_OUT - 1);
    localparam logic [IDX_W:0]   DEPTH = (IDX_W + 1)'(N_OUT);

    state_t            state_q;
    logic [IDX_W-1:0]  count_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] max_q;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] buf_q [N_OUT];

    logic              beat_d;
    logic              take_d;
    logic              rd_ok_d;
    logic [DATA_W-1:0] rd_d;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        beat_d  = (state_q == COLLECT) && in_en_i;
        take_d  = beat_d &&
                  ((count_q == '0) ||
                   ($signed(in_data_i) > $signed(max_q)));
        rd_ok_d = ({1'b0, rd_addr_i} < DEPTH);
        rd_d    = '0;
        if (rd_ok_d) begin
            rd_d = buf_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= COLLECT;
                        count_q <= '0;
                        idx_q   <= '0;
                        max_q   <= '0;
                        err_q   <= in_en_i;
                    end else if (in_en_i) begin
                        err_q <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (start_i) begin
                        err_q <= 1'b1;
                    end
                    if (beat_d) begin
                        count_q <= count_q + 1'b1;
                        if (take_d) begin
                            idx_q <= count_q;
                            max_q <= in_data_i;
                        end
                        if (count_q == LAST) begin
                            state_q <= RESULT;
                            valid_q <= 1'b1;
                        end
                    end
                end
                RESULT: begin
                    if (start_i || in_en_i) begin
                        err_q <= 1'b1;
                    end
                    if (res_ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Buffer is deliberately not reset; stale logits stay readable.
    always_ff @(posedge clk_i) begin
        if (!rst_i && beat_d) begin
            buf_q[count_q] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign res_valid_o = valid_q;
    assign res_idx_o   = idx_q;
    assign res_max_o   = max_q;
    assign busy_o      = (state_q != IDLE);
    assign err_o       = err_q;
    assign rd_data_o   = rd_q;

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Scoreboard bench for fc_argmax_collector: random and directed frames
// checked against an array-based argmax reference model.
module tb_fc_argmax_collector;

    localparam int N  = 10;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef logic [DW-1:0] frame_t [N];
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
    } res_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          in_en_i;
    logic [DW-1:0] in_data_i;
    logic          res_valid_o;
    logic          res_ready_i;
    logic [IW-1:0] res_idx_o;
    logic [DW-1:0] res_max_o;
    logic          busy_o;
    logic          err_o;
    logic [IW-1:0] rd_addr_i;
    logic [DW-1:0] rd_data_o;

    int     vectors = 0;
    int     miscompares = 0;
    res_t   exp_q[$];
    frame_t last_frame;
    frame_t fa, ff, fm, fr;

    fc_argmax_collector #(.N_OUT(N), .DATA_W(DW), .IDX_W(IW)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .in_en_i    (in_en_i),
        .in_data_i  (in_data_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_idx_o  (res_idx_o),
        .res_max_o  (res_max_o),
        .busy_o     (busy_o),
        .err_o      (err_o),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic res_t ref_argmax(input frame_t f);
        res_t r;
        r.idx = '0;
        r.mx  = f[0];
        for (int i = 1; i < N; i++) begin
            if ($signed(f[i]) > $signed(r.mx)) begin
                r.idx = IW'(i);
                r.mx  = f[i];
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_logit();
        case ($urandom_range(3, 0))
            0: return DW'($urandom_range(6, 0)) - 32'd3;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && res_valid_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_result: got idx %0d max %h, expected none",
                         res_idx_o, res_max_o);
            end else begin
                chk("res_idx", 32'(res_idx_o), 32'(exp_q[0].idx));
                chk("res_max", res_max_o, exp_q[0].mx);
                if (res_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_frame(input frame_t f, input int gmin, input int gmax,
                             input int rdly, input bit inject,
                             input bit start_beat);
        int g;
        exp_q.push_back(ref_argmax(f));
        last_frame = f;
        start_i = 1'b1;
        if (start_beat) begin
            in_en_i   = 1'b1;
            in_data_i = 32'h7FFF_FFFF;
        end
        tick();
        start_i = 1'b0;
        in_en_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'(1));
        chk("err_after_start", 32'(err_o), 32'(start_beat));
        for (int i = 0; i < N; i++) begin
            g = int'($urandom_range(gmax, gmin));
            repeat (g) tick();
            in_en_i   = 1'b1;
            in_data_i = f[i];
            tick();
            in_en_i = 1'b0;
            if (i < N - 1) chk("no_early_valid", 32'(res_valid_o), 32'(0));
        end
        chk("valid_after_last", 32'(res_valid_o), 32'(1));
        for (int i = 0; i < rdly; i++) begin
            if (inject && i == 1) begin
                in_en_i   = 1'b1;
                in_data_i = 32'h7FFF_FFFF;
                tick();
                in_en_i = 1'b0;
                chk("err_beat_in_result", 32'(err_o), 32'(1));
            end else begin
                tick();
            end
        end
        res_ready_i = 1'b1;
        for (int t = 0; t < 50 && res_valid_o; t++) tick();
        res_ready_i = 1'b0;
        chk("handshake_done", 32'(res_valid_o), 32'(0));
        chk("idle_after_accept", 32'(busy_o), 32'(0));
    endtask

    task automatic readback();
        int addrs [11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12};
        for (int k = 0; k < 11; k++) begin
            rd_addr_i = IW'(addrs[k]);
            tick();
            chk($sformatf("rd_data[%0d]", addrs[k]), rd_data_o,
                (addrs[k] < N) ? last_frame[addrs[k]] : 32'd0);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        in_en_i     = 1'b0;
        in_data_i   = '0;
        res_ready_i = 1'b0;
        rd_addr_i   = '0;
        fa = '{32'd5, -32'd3, 32'd17, 32'd2, 32'd17,
               32'd0, -32'd100, 32'd9, 32'd16, 32'd1};
        for (int i = 0; i < N; i++) ff[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) fm[i] = 32'h8000_0000;
        fm[N-1] = 32'd3;

        repeat (2) tick();
        chk("rst_valid", 32'(res_valid_o), 32'(0));
        chk("rst_idx", 32'(res_idx_o), 32'(0));
        chk("rst_max", res_max_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_err", 32'(err_o), 32'(0));
        chk("rst_rd", rd_data_o, 32'd0);
        rst_i = 1'b0;
        tick();

        run_frame(fa, 0, 0, 0, 1'b0, 1'b0);
        readback();

        run_frame(ff, 1, 3, 1, 1'b0, 1'b0);
        run_frame(fm, 0, 0, 2, 1'b0, 1'b0);

        for (int i = 0; i < N; i++) fr[i] = rand_logit();
        run_frame(fr, 0, 1, 5, 1'b1, 1'b0);
        chk("err_sticky", 32'(err_o), 32'(1));
        readback();
        for (int i = 0; i < N; i++) fr[i] = rand_logit();
        run_frame(fr, 0, 2, 0, 1'b0, 1'b0);

        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_en_i   = 1'b1;
            in_data_i = rand_logit();
            tick();
        end
        in_en_i = 1'b0;
        rst_i   = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("abort_busy", 32'(busy_o), 32'(0));
        chk("abort_valid", 32'(res_valid_o), 32'(0));
        chk("abort_idx", 32'(res_idx_o), 32'(0));
        repeat (3) tick();
        chk("abort_no_valid", 32'(res_valid_o), 32'(0));
        run_frame(fa, 0, 0, 0, 1'b0, 1'b0);

        in_en_i   = 1'b1;
        in_data_i = 32'd55;
        tick();
        in_en_i = 1'b0;
        chk("err_beat_in_idle", 32'(err_o), 32'(1));
        chk("idle_beat_busy", 32'(busy_o), 32'(0));
        run_frame(fa, 0, 1, 1, 1'b0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < N; i++) fr[i] = rand_logit();
            run_frame(fr, 0, 2, int'($urandom_range(3, 0)), 1'b0, 1'b0);
        end
        readback();

        repeat (3) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
